// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Brief    : Operation encodings and FSM state type for the iterative
//             multiply/divide unit.
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [1:0] OP_DIVU  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_MULT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } stateT;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_step
//  Brief    : One radix-2 iteration: restoring shift-subtract for divide,
//             shift-add for multiply (multiply path only with MULDIV_MUL_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int W = 32
) (
`ifdef MULDIV_MUL_EN
    input  logic         isMul,
`endif
    input  logic [W-1:0] hi,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] b,
    output logic [W-1:0] nextHi,
    output logic [W-1:0] nextLo
);

    logic [W:0] w_trial;
    logic [W:0] w_diff;
`ifdef MULDIV_MUL_EN
    logic [W:0] w_sum;
`endif

    always_comb begin
        // Divide: {hi,lo} holds {partial remainder, dividend bits / quotient}
        w_trial = {hi, lo[W-1]};
        w_diff  = w_trial - {1'b0, b};
        if (w_diff[W]) begin
            nextHi = w_trial[W-1:0];
            nextLo = {lo[W-2:0], 1'b0};
        end else begin
            nextHi = w_diff[W-1:0];
            nextLo = {lo[W-2:0], 1'b1};
        end
`ifdef MULDIV_MUL_EN
        // Multiply: lo holds the multiplier, consumed LSB first
        w_sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : {(W+1){1'b0}});
        if (isMul) begin
            nextHi = w_sum[W:1];
            nextLo = {w_sum[0], lo[W-1:1]};
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_iter
//  Brief    : Iterative W-bit multiply/divide unit with annul and divide-by-
//             zero flag. Define MULDIV_MUL_EN to include MULTU/MULT support.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic           annul,
    input  logic [W-1:0]   opa,
    input  logic [W-1:0]   opb,
    output logic           busy,
    output logic           ready,
    output logic           divz,
    output logic [2*W-1:0] result
);

    localparam int CNT_W = $clog2(W + 1);

    stateT              r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_hi;
    logic [W-1:0]       r_lo;
    logic [W-1:0]       r_b;
    logic               r_negQ;
    logic               r_negR;
    logic               r_divzPend;
    logic               r_ready;
    logic               r_divz;
    logic [2*W-1:0]     r_result;
`ifdef MULDIV_MUL_EN
    logic               r_isMul;
`endif

    logic               w_launch;
    logic               w_negA;
    logic               w_negB;
    logic [W-1:0]       w_absA;
    logic [W-1:0]       w_absB;
    logic [W-1:0]       w_nextHi;
    logic [W-1:0]       w_nextLo;
    logic [W-1:0]       w_quot;
    logic [W-1:0]       w_rem;
    logic [2*W-1:0]     w_fixResult;

`ifdef MULDIV_MUL_EN
    assign w_launch = start & ~annul;
`else
    assign w_launch = start & ~annul & ~op[1];
`endif

    assign w_negA = op[0] & opa[W-1];
    assign w_negB = op[0] & opb[W-1];
    assign w_absA = w_negA ? -opa : opa;
    assign w_absB = w_negB ? -opb : opb;

    // Both ops use lo=|opa|, b=|opb|; multiplication is symmetric
    muldiv_step #(.W(W)) u_step (
`ifdef MULDIV_MUL_EN
        .isMul  (r_isMul),
`endif
        .hi     (r_hi),
        .lo     (r_lo),
        .b      (r_b),
        .nextHi (w_nextHi),
        .nextLo (w_nextLo)
    );

    // Divide-by-zero leaves quotient all ones and remainder |opa|, so the
    // remainder sign fix alone restores the raw dividend.
    always_comb begin
        w_quot      = r_divzPend ? {W{1'b1}} : (r_negQ ? -r_lo : r_lo);
        w_rem       = r_negR ? -r_hi : r_hi;
        w_fixResult = {w_rem, w_quot};
`ifdef MULDIV_MUL_EN
        if (r_isMul) begin
            w_fixResult = r_negQ ? -{r_hi, r_lo} : {r_hi, r_lo};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_b        <= '0;
            r_negQ     <= 1'b0;
            r_negR     <= 1'b0;
            r_divzPend <= 1'b0;
            r_ready    <= 1'b0;
            r_divz     <= 1'b0;
            r_result   <= '0;
`ifdef MULDIV_MUL_EN
            r_isMul    <= 1'b0;
`endif
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_hi       <= '0;
                        r_lo       <= w_absA;
                        r_b        <= w_absB;
                        r_negQ     <= w_negA ^ w_negB;
                        r_negR     <= w_negA;
                        r_divzPend <= ~op[1] & (opb == '0);
                        r_cnt      <= CNT_W'(W);
`ifdef MULDIV_MUL_EN
                        r_isMul    <= op[1];
`endif
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    if (annul) begin
                        r_state <= IDLE;
                    end else begin
                        r_hi  <= w_nextHi;
                        r_lo  <= w_nextLo;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (annul) begin
                        r_state <= IDLE;
                    end else begin
                        r_result <= w_fixResult;
                        r_divz   <= r_divzPend;
                        r_ready  <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign ready  = r_ready;
    assign divz   = r_divz;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_iter
//  Brief    : Scoreboard bench for muldiv_iter (W=32), both MULDIV_MUL_EN builds.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [1:0]     op;
    logic           annul;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic           busy;
    logic           ready;
    logic           divz;
    logic [2*W-1:0] result;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           dz;
        int             cyc;
    } sbEntryT;

    sbEntryT        sb[$];
    sbEntryT        mon;
    int             cyc = 0;
    int             nTotal = 0;
    int             nBad = 0;
    logic [2*W-1:0] lastRes = '0;

    muldiv_iter #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .annul  (annul),
        .opa    (opa),
        .opb    (opb),
        .busy   (busy),
        .ready  (ready),
        .divz   (divz),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTotal++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb2;
        sa  = a;
        sb2 = b;
        case (o)
            OP_DIVU:  return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, a};
                return {sa % sb2, sa / sb2};
            end
            OP_MULTU: return {32'h0, a} * {32'h0, b};
            default:  return 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && ready) begin
            if (sb.size() == 0) begin
                checkVal("spuriousReady", 64'd1, 64'd0);
            end else begin
                mon = sb.pop_front();
                checkVal("result", result, mon.res);
                checkVal("divz", {63'd0, divz}, {63'd0, mon.dz});
                checkVal("latency", 64'(cyc - mon.cyc), 64'(W + 1));
                lastRes = mon.res;
            end
        end
    end

    // Called at a negedge with the unit idle; returns at a negedge once idle.
    task automatic doOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input logic expDz);
        int n;
        start = 1'b1; op = o; opa = a; opb = b;
        sb.push_back('{res: exp, dz: expDz, cyc: cyc + 1});
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); opa = $urandom; opb = $urandom;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkVal("busyLen", 64'(n), 64'(W + 2));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          n;

        rst = 1'b1; start = 1'b0; op = OP_DIVU; annul = 1'b0; opa = '0; opb = '0;
        #12;
        checkVal("rstBusy", {63'd0, busy}, 64'd0);
        checkVal("rstReady", {63'd0, ready}, 64'd0);
        checkVal("rstDivz", {63'd0, divz}, 64'd0);
        checkVal("rstResult", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        doOp(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
        doOp(OP_DIV, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
        doOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0);
        doOp(OP_DIVU, 32'h1234, 32'd0, {32'h1234, 32'hFFFFFFFF}, 1'b1);
        doOp(OP_DIV, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1);
        doOp(OP_DIV, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1'b0);
`ifdef MULDIV_MUL_EN
        doOp(OP_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0);
        doOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
`else
        start = 1'b1; op = OP_MULT; opa = 32'hFFFFFFFD; opb = 32'd5;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (busy) n++;
            @(negedge clk);
        end
        checkVal("noMulBusy", 64'(n), 64'd0);
`endif

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom);
`ifndef MULDIV_MUL_EN
            ro[1] = 1'b0;
`endif
            ra = (i % 3 == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20));
            doOp(ro, ra, rb, model(ro, ra, rb), ~ro[1] && (rb == 0));
        end

        // Annul mid-CALC; start held during busy must be ignored
        start = 1'b1; op = OP_DIVU; opa = 32'd50; opb = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; opa = 32'd99; opb = 32'd3;
        repeat (5) @(negedge clk);
        start = 1'b0; annul = 1'b1;
        checkVal("annulBusyBefore", {63'd0, busy}, 64'd1);
        @(negedge clk);
        annul = 1'b0;
        checkVal("annulIdle", {63'd0, busy}, 64'd0);
        checkVal("annulResult", result, lastRes);
        repeat (W + 4) @(negedge clk);
        checkVal("annulStillIdle", {63'd0, busy}, 64'd0);

        doOp(OP_DIVU, 32'd81, 32'd9, {32'd0, 32'd9}, 1'b0);

        // Asynchronous reset mid-CALC
        start = 1'b1; op = OP_DIVU; opa = 32'd1000; opb = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkVal("asyncRstBusy", {63'd0, busy}, 64'd0);
        checkVal("asyncRstResult", result, 64'd0);
        lastRes = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        doOp(OP_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

        repeat (5) @(negedge clk);
        checkVal("sbEmpty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
`default_nettype wire
